// File: rtl/keypad_scanner_if.sv
// keypad_scanner_if: keypad matrix drive/sense plus the key strobe toward the lock controller
interface keypad_scanner_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       valid_out;
    logic [3:0] key_out;
    modport master (input row_in, output col_out, valid_out, key_out);
    modport slave (output row_in, input col_out, valid_out, key_out);
endinterface

// File: rtl/keypad_scanner.sv
// keypad_scanner: scans a 4x4 active-low keypad, debounces, and emits one key code pulse per press
module keypad_scanner #(
    parameter int SCAN_CYCLES     = 4,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input logic               clk,
    input logic               reset,
    keypad_scanner_if.master  kp
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int SW = $clog2(SCAN_CYCLES);
    localparam logic [3:0] KEY_MAP [16] = '{
        4'd1,  4'd2, 4'd3,  4'd11,
        4'd4,  4'd5, 4'd6,  4'd12,
        4'd7,  4'd8, 4'd9,  4'd13,
        4'd10, 4'd0, 4'd15, 4'd14
    };
    typedef enum logic [1:0] {SCAN, DEBOUNCE, EMIT, HOLD} state_t;
    state_t         state, next;
    logic [3:0]     row_m, row_s, cap_row;
    logic [1:0]     idx, row_idx;
    logic [SW-1:0]  dwell;
    logic [DW-1:0]  deb_cnt, rel_cnt;
    logic           last_dwell, one_key, deb_done, rel_done;
    // a single zero row bit means exactly one key in this column; more is a ghost/multi-press
    assign last_dwell = dwell == SW'(SCAN_CYCLES - 1);
    assign one_key    = row_s != 4'hF && ((~row_s) & ((~row_s) - 4'd1)) == 4'h0;
    assign deb_done   = row_s == cap_row && int'(deb_cnt) + 1 >= DEBOUNCE_CYCLES;
    assign rel_done   = row_s == 4'hF && int'(rel_cnt) + 1 >= DEBOUNCE_CYCLES;
    assign row_idx    = !cap_row[0] ? 2'd0 : !cap_row[1] ? 2'd1 : !cap_row[2] ? 2'd2 : 2'd3;
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SCAN;
            row_m        <= 4'hF;
            row_s        <= 4'hF;
            cap_row      <= 4'hF;
            idx          <= 2'd0;
            dwell        <= '0;
            deb_cnt      <= '0;
            rel_cnt      <= '0;
            kp.valid_out <= 1'b0;
            kp.key_out   <= 4'h0;
        end else begin
            state        <= next;
            row_m        <= kp.row_in;
            row_s        <= row_m;
            kp.valid_out <= next == EMIT;
            if (next == EMIT)
                kp.key_out <= KEY_MAP[{row_idx, idx}];
            case (state)
                SCAN: begin
                    if (last_dwell && one_key) begin
                        cap_row <= row_s;
                        deb_cnt <= DW'(1);
                        dwell   <= '0;
                    end else if (last_dwell) begin
                        idx   <= idx + 2'd1;
                        dwell <= '0;
                    end else
                        dwell <= dwell + 1'b1;
                end
                DEBOUNCE: begin
                    if (row_s != cap_row) begin
                        deb_cnt <= '0;
                        dwell   <= '0;
                    end else if (int'(deb_cnt) < DEBOUNCE_CYCLES)
                        deb_cnt <= deb_cnt + 1'b1;
                end
                EMIT: rel_cnt <= '0;
                HOLD: begin
                    if (row_s != 4'hF)
                        rel_cnt <= '0;
                    else if (rel_done) begin
                        rel_cnt <= '0;
                        idx     <= 2'd0;
                        dwell   <= '0;
                    end else
                        rel_cnt <= rel_cnt + 1'b1;
                end
            endcase
        end
    end
    always_comb
        next = state == SCAN     ? (last_dwell && one_key ? DEBOUNCE : SCAN) :
               state == DEBOUNCE ? (row_s != cap_row ? SCAN : deb_done ? EMIT : DEBOUNCE) :
               state == EMIT     ? HOLD :
                                   (rel_done ? SCAN : HOLD);
    always_comb
        kp.col_out = ~(4'b0001 << idx);
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed checks of scanning, debounce, ghost rejection and mid-debounce reset
module tb_keypad_scanner;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] pressed = '0;
    logic [3:0]  rows;
    int          n_cmp = 0, n_err = 0;
    int          cyc = 0, pulses = 0, last_key = -1, last_cyc = 0;
    int          keyq[$];
    keypad_scanner_if kif ();
    keypad_scanner dut (.clk(clk), .reset(reset), .kp(kif));
    always #5 clk = ~clk;
    // keypad model: a row reads low only when a pressed key sits on the driven column
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !kif.col_out[c]) rows[r] = 1'b0;
    end
    assign kif.row_in = rows;
    always @(posedge clk) begin
        #2;
        cyc++;
        if (kif.valid_out) begin
            pulses++;
            last_key = int'(kif.key_out);
            last_cyc = cyc;
            keyq.push_back(int'(kif.key_out));
        end
    end
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask
    initial begin
        int p0, t0, base, run;
        int kidx[5] = '{1, 4, 10, 13, 12};
        int kexp[5] = '{2, 4, 9, 0, 10};
        logic [3:0] ec;
        tick(2);
        check("rst_col", int'(kif.col_out), 14);
        check("rst_valid", int'(kif.valid_out), 0);
        check("rst_key", int'(kif.key_out), 0);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ec = ~(4'b0001 << (i / 4));
            check($sformatf("t1_col%0d", i), int'(kif.col_out), int'(ec));
            tick(1);
        end
        tick(100);
        check("t1_no_pulse", pulses, 0);
        p0 = pulses;
        pressed[1] = 1'b1;
        t0 = cyc;
        tick(50);
        check("t2_pulses", pulses - p0, 1);
        check("t2_key", last_key, 2);
        check("t2_latency_ok", int'(last_cyc - t0 <= 23), 1);
        pressed = '0;
        tick(40);
        base = keyq.size();
        p0 = pulses;
        for (int i = 0; i < 5; i++) begin
            pressed[kidx[i]] = 1'b1;
            tick(40);
            pressed = '0;
            tick(40);
        end
        check("t3_pulses", pulses - p0, 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("t3_key%0d", i), base + i < keyq.size() ? keyq[base+i] : -1, kexp[i]);
        p0 = pulses;
        for (int g = 0; g < 3; g++) begin
            pressed[6] = 1'b1;
            tick(3);
            pressed[6] = 1'b0;
            tick(5);
        end
        tick(10);
        check("t4_glitch_pulses", pulses - p0, 0);
        pressed[6] = 1'b1;
        tick(50);
        check("t4_pulses", pulses - p0, 1);
        check("t4_key", last_key, 6);
        pressed = '0;
        tick(40);
        p0 = pulses;
        pressed[0] = 1'b1;
        pressed[4] = 1'b1;
        tick(60);
        check("t5_ghost_pulses", pulses - p0, 0);
        pressed[4] = 1'b0;
        tick(40);
        check("t5_pulses", pulses - p0, 1);
        check("t5_key", last_key, 1);
        pressed = '0;
        tick(40);
        for (int k = 0; k < 40 && kif.col_out != 4'b1110; k++) tick(1);
        p0 = pulses;
        pressed[5] = 1'b1;
        run = 0;
        for (int k = 0; k < 60 && run < 5; k++) begin
            tick(1);
            run = (kif.col_out == 4'b1101) ? run + 1 : 0;
        end
        check("t6_in_debounce", run, 5);
        reset = 1'b1;
        tick(1);
        check("t6_rst_col", int'(kif.col_out), 14);
        check("t6_rst_valid", int'(kif.valid_out), 0);
        check("t6_rst_key", int'(kif.key_out), 0);
        reset = 1'b0;
        check("t6_dropped", pulses - p0, 0);
        tick(40);
        check("t6_pulses", pulses - p0, 1);
        check("t6_key", last_key, 5);
        pressed = '0;
        tick(20);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
